// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter that shares one single-port RAM between an instruction
// fetch port (read only) and a load/store port. Only one transaction is in
// flight at a time. Load/store wins by default. Fetch wins when load/store is
// idle, or when fetch has lost STARVE_LIMIT arbitrations in a row.
// All outputs are registered.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   if_req/if_adr                fetch request (held until if_gnt)
//   if_gnt/if_done/if_rdata      fetch grant pulse, completion pulse, read data
//   ls_req/ls_we/ls_adr/ls_wdata load/store request (held until ls_gnt)
//   ls_gnt/ls_done/ls_rdata      load/store grant pulse, completion pulse, load data
//   ram_req/ram_we/ram_adr/ram_wdata  request to the shared RAM
//   ram_ready/ram_rvalid/ram_rdata    RAM accept, read-valid and read data
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_adr,
    output logic                  if_gnt,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_adr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_adr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic                  ram_ready,
    input  logic                  ram_rvalid,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic       r_owner_if;   // 1: fetch owns the current transaction
    logic       w_if_wins;

    assign w_if_wins = if_req && (!ls_req || (r_starve_cnt == LIMIT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Returning to IDLE also discards any RAM response still in flight
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_owner_if   <= 1'b0;
            if_gnt       <= 1'b0;
            if_done      <= 1'b0;
            if_rdata     <= '0;
            ls_gnt       <= 1'b0;
            ls_done      <= 1'b0;
            ls_rdata     <= '0;
            ram_req      <= 1'b0;
            ram_we       <= 1'b0;
            ram_adr      <= '0;
            ram_wdata    <= '0;
        end else begin
            // Grant and done are single-cycle pulses
            if_gnt  <= 1'b0;
            ls_gnt  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (if_req || ls_req) begin
                        r_state <= S_REQ;
                        ram_req <= 1'b1;
                        if (w_if_wins) begin
                            r_owner_if   <= 1'b1;
                            if_gnt       <= 1'b1;
                            ram_adr      <= if_adr;
                            ram_we       <= 1'b0;
                            r_starve_cnt <= 4'd0;
                        end else begin
                            r_owner_if <= 1'b0;
                            ls_gnt     <= 1'b1;
                            ram_adr    <= ls_adr;
                            ram_we     <= ls_we;
                            ram_wdata  <= ls_wdata;
                            // Fetch lost while asking: count toward forced win
                            if (if_req && (r_starve_cnt != LIMIT))
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end

                S_REQ: begin
                    if (ram_ready) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        if (ram_we) begin
                            // Store completes on acceptance; rvalid is ignored
                            ls_done <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (ram_rvalid) begin
                            // Zero-latency read: skip RESP entirely
                            if (r_owner_if) begin
                                if_rdata <= ram_rdata;
                                if_done  <= 1'b1;
                            end else begin
                                ls_rdata <= ram_rdata;
                                ls_done  <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (ram_rvalid) begin
                        if (r_owner_if) begin
                            if_rdata <= ram_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            ls_rdata <= ram_rdata;
                            ls_done  <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, so each step() observes the result of one clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_adr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_adr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_adr;
    logic [31:0] ram_wdata;
    logic        ram_ready;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_adr    (ls_adr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_adr   (ram_adr),
        .ram_wdata (ram_wdata),
        .ram_ready (ram_ready),
        .ram_rvalid(ram_rvalid),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_if_gnt"},  {31'd0, if_gnt},  32'd0);
        chk({tag, "_ls_gnt"},  {31'd0, ls_gnt},  32'd0);
        chk({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
        chk({tag, "_ls_done"}, {31'd0, ls_done}, 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        if_req     = 1'b0;
        if_adr     = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_adr     = '0;
        ls_wdata   = '0;
        ram_ready  = 1'b0;
        ram_rvalid = 1'b0;
        ram_rdata  = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk_quiet("rst");
        chk("rst_ram_req",   {31'd0, ram_req}, 32'd0);
        chk("rst_ram_we",    {31'd0, ram_we},  32'd0);
        chk("rst_ram_adr",   ram_adr,   32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_if_rdata",  if_rdata,  32'd0);
        chk("rst_ls_rdata",  ls_rdata,  32'd0);
        resetn = 1'b1;

        // rvalid while idle is ignored
        ram_rvalid = 1'b1;
        ram_rdata  = 32'hCAFE_0001;
        step();
        ram_rvalid = 1'b0;
        chk_quiet("idle_rvalid");
        chk("idle_rvalid_req", {31'd0, ram_req}, 32'd0);
        chk("idle_rvalid_ls_rdata", ls_rdata, 32'd0);

        // ---------------- fetch only, RESP path ----------------
        if_req = 1'b1;
        if_adr = 32'h100;
        step();                                   // cycle 1
        chk("f_gnt1",   {31'd0, if_gnt},  32'd1);
        chk("f_req1",   {31'd0, ram_req}, 32'd1);
        chk("f_adr1",   ram_adr,          32'h100);
        chk("f_we1",    {31'd0, ram_we},  32'd0);
        if_req = 1'b0;
        step();                                   // cycle 2
        chk("f_gnt2",   {31'd0, if_gnt},  32'd0);
        chk("f_req2",   {31'd0, ram_req}, 32'd1);
        ram_ready = 1'b1;
        step();                                   // cycle 3 (RESP)
        chk("f_req3",   {31'd0, ram_req}, 32'd0);
        chk("f_done3",  {31'd0, if_done}, 32'd0);
        ram_ready  = 1'b0;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'hDEAD_BEEF;
        step();                                   // cycle 4
        chk("f_done4",  {31'd0, if_done}, 32'd1);
        chk("f_rdata4", if_rdata,         32'hDEAD_BEEF);
        chk("f_lsdone4", {31'd0, ls_done}, 32'd0);
        ram_rvalid = 1'b0;
        ram_rdata  = 32'h0;
        step();
        chk("f_done5",  {31'd0, if_done}, 32'd0);
        chk("f_rdata5", if_rdata,         32'hDEAD_BEEF);

        // ---------------- simultaneous store and fetch ----------------
        if_req    = 1'b1;
        if_adr    = 32'h200;
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_adr    = 32'h20;
        ls_wdata  = 32'h55;
        ram_ready = 1'b1;
        step();
        chk("s_lsgnt",  {31'd0, ls_gnt},  32'd1);
        chk("s_ifgnt",  {31'd0, if_gnt},  32'd0);
        chk("s_we",     {31'd0, ram_we},  32'd1);
        chk("s_adr",    ram_adr,          32'h20);
        chk("s_wdata",  ram_wdata,        32'h55);
        ls_req = 1'b0;
        step();
        chk("s_lsdone", {31'd0, ls_done}, 32'd1);
        chk("s_req_off", {31'd0, ram_req}, 32'd0);
        step();
        chk("s_ifgnt2", {31'd0, if_gnt},  32'd1);
        chk("s_adr2",   ram_adr,          32'h200);
        chk("s_we2",    {31'd0, ram_we},  32'd0);
        if_req = 1'b0;
        step();                                   // RESP
        ram_ready  = 1'b0;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h0000_A5A5;
        step();
        chk("s_ifdone", {31'd0, if_done}, 32'd1);
        chk("s_ifrd",   if_rdata,         32'h0000_A5A5);
        ram_rvalid = 1'b0;
        step();

        // ---------------- starvation: 4 ls grants, then 1 if grant ----------------
        if_req     = 1'b1;
        if_adr     = 32'h400;
        ls_req     = 1'b1;
        ls_we      = 1'b0;
        ls_adr     = 32'h40;
        ram_ready  = 1'b1;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h0000_0BB0;
        for (int k = 0; k < 10; k++) begin
            step();                               // grant cycle
            chk($sformatf("st_ls_gnt%0d", k), {31'd0, ls_gnt},
                ((k == 4) || (k == 9)) ? 32'd0 : 32'd1);
            chk($sformatf("st_if_gnt%0d", k), {31'd0, if_gnt},
                ((k == 4) || (k == 9)) ? 32'd1 : 32'd0);
            if (k == 9) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            step();                               // done cycle
            chk($sformatf("st_ls_done%0d", k), {31'd0, ls_done},
                ((k == 4) || (k == 9)) ? 32'd0 : 32'd1);
        end
        ram_ready  = 1'b0;
        ram_rvalid = 1'b0;
        step();
        chk_quiet("st_after");

        // ---------------- ready and rvalid in the same cycle ----------------
        ls_req = 1'b1;
        ls_we  = 1'b0;
        ls_adr = 32'h44;
        step();
        chk("z_gnt", {31'd0, ls_gnt}, 32'd1);
        ls_req     = 1'b0;
        ram_ready  = 1'b1;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h1234;
        step();
        chk("z_done",  {31'd0, ls_done}, 32'd1);
        chk("z_rdata", ls_rdata,         32'h1234);
        chk("z_req",   {31'd0, ram_req}, 32'd0);
        ram_ready  = 1'b0;
        ram_rvalid = 1'b0;
        step();
        chk("z_done2", {31'd0, ls_done}, 32'd0);

        // ---------------- ram_ready held low for 10 cycles ----------------
        if_req = 1'b1;
        if_adr = 32'h300;
        step();
        chk("w_gnt", {31'd0, if_gnt}, 32'd1);
        if_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("w_req%0d", k),  {31'd0, ram_req}, 32'd1);
            chk($sformatf("w_adr%0d", k),  ram_adr,          32'h300);
            chk($sformatf("w_done%0d", k), {31'd0, if_done}, 32'd0);
        end
        ram_ready = 1'b1;
        step();
        ram_ready  = 1'b0;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h77;
        step();
        chk("w_done_end", {31'd0, if_done}, 32'd1);
        chk("w_rdata",    if_rdata,         32'h77);
        ram_rvalid = 1'b0;
        step();

        // ---------------- reset while in RESP, stale rvalid afterwards ----------------
        ls_req = 1'b1;
        ls_we  = 1'b0;
        ls_adr = 32'h10;
        step();
        chk("r_gnt", {31'd0, ls_gnt}, 32'd1);
        ls_req    = 1'b0;
        ram_ready = 1'b1;
        step();                                   // now in RESP
        chk("r_resp_req", {31'd0, ram_req}, 32'd0);
        ram_ready = 1'b0;
        resetn    = 1'b0;
        step();
        resetn     = 1'b1;
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h0000_0BAD;
        step();
        chk_quiet("r_stale");
        chk("r_ls_rdata",  ls_rdata,  32'd0);
        chk("r_if_rdata",  if_rdata,  32'd0);
        chk("r_ram_req",   {31'd0, ram_req}, 32'd0);
        chk("r_ram_we",    {31'd0, ram_we},  32'd0);
        chk("r_ram_adr",   ram_adr,   32'd0);
        chk("r_ram_wdata", ram_wdata, 32'd0);
        ram_rvalid = 1'b0;
        step();
        chk_quiet("r_after");
        chk("r_ls_rdata2", ls_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
